// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory request/response, redirect and decode-side handshake.
// The master modport is the fetch_queue; the slave modport is memory, decode and redirect source.
interface fetch_queue_if #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 4
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0]  i_addr;
    logic               i_req;
    logic               i_gnt;
    logic               i_rvalid;
    logic [INSTR_W-1:0] i_rdata;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [OCC_W-1:0]   occupancy;

    modport master (
        output i_addr, i_req,
        input  i_gnt, i_rvalid, i_rdata,
        input  redirect, redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr, out_pc, occupancy
    );

    modport slave (
        input  i_addr, i_req,
        output i_gnt, i_rvalid, i_rdata,
        output redirect, redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr, out_pc, occupancy
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: request/grant fetch engine feeding an in-order PC-tagged prefetch FIFO.
// Define FETCH_QUEUE_BYPASS_EN to let a response reach decode in the same cycle when the FIFO is empty.
module fetch_queue #(
    parameter int INSTR_W  = 16,
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 4,
    parameter int PC_STEP  = 2,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_queue_if.master   bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(RESET_PC);
    localparam logic [CNT_W:0]    CAP      = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  resp_pc;
    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic [ADDR_W-1:0]  mem_pc [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   drop_cnt;

    logic [CNT_W:0]     in_use;
    logic               issue;
    logic               accept;
    logic               rsp_seen;
    logic               rsp_keep;
    logic               bypass_take;
    logic               push;
    logic               pop;
    logic               head_valid;

    // Queued plus in-flight instructions bound new requests, so the FIFO can never overflow.
    assign in_use   = {1'b0, count} + {1'b0, outstanding};
    assign issue    = rst_n & ~bus.redirect & (in_use < CAP);
    assign accept   = issue & bus.i_gnt;
    assign rsp_seen = bus.i_rvalid & (outstanding != '0);
    assign rsp_keep = rsp_seen & (drop_cnt == '0) & ~bus.redirect;
    assign head_valid = (count != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass_live;
    assign bypass_live   = rsp_keep & ~head_valid;
    assign bypass_take   = bypass_live & bus.out_ready;
    assign bus.out_valid = ~bus.redirect & (head_valid | bypass_live);
    assign bus.out_instr = bypass_live ? bus.i_rdata : mem_instr[rd_ptr];
    assign bus.out_pc    = bypass_live ? resp_pc : mem_pc[rd_ptr];
`else
    assign bypass_take   = 1'b0;
    assign bus.out_valid = ~bus.redirect & head_valid;
    assign bus.out_instr = mem_instr[rd_ptr];
    assign bus.out_pc    = mem_pc[rd_ptr];
`endif

    // A bypassed transfer never touches the FIFO, so pop only counts real head entries.
    assign pop  = bus.out_valid & bus.out_ready & head_valid;
    assign push = rsp_keep & ~bypass_take;

    assign bus.i_req     = issue;
    assign bus.i_addr    = fetch_pc;
    assign bus.occupancy = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= START_PC;
            resp_pc     <= START_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr[i] <= '0;
                mem_pc[i]    <= '0;
            end
        end else if (bus.redirect) begin
            // Every response still owed belongs to the old path and must be swallowed.
            fetch_pc    <= bus.redirect_pc;
            resp_pc     <= bus.redirect_pc;
            wr_ptr      <= rd_ptr;
            count       <= '0;
            outstanding <= outstanding - CNT_W'(rsp_seen);
            drop_cnt    <= outstanding - CNT_W'(rsp_seen);
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + STEP;
            end
            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(rsp_seen);
            if (rsp_seen && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
            if (rsp_keep) begin
                resp_pc <= resp_pc + STEP;
            end
            if (push) begin
                mem_instr[wr_ptr] <= bus.i_rdata;
                mem_pc[wr_ptr]    <= resp_pc;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule
